// File: rtl/fill_sequencer.sv
// fill_sequencer: pill-bottling sequencing controller with BCD pill and bottle counts and supervision timers.
// Optional feature macro FILL_SEQ_AUTO_RESUME_EN: ERROR recovers without ack once its fault clears.
module fill_sequencer #(
  parameter int TICK_DIV   = 1000,
  parameter int SWITCH_SEC = 2,
  parameter int HOPPER_SEC = 5
) (
  input  logic        clk_1khz,
  input  logic        clr,
  input  logic        start,
  input  logic        ack,
  input  logic        estop,
  input  logic [11:0] target_pills,
  input  logic [7:0]  target_bottles,
  input  logic        pill_pulse,
  input  logic        conveyor_ok,
  output logic [2:0]  state,
  output logic [11:0] now_pills,
  output logic [7:0]  now_bottles,
  output logic        switch_req,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_SWITCHING = 3'd2,
    ST_DONE      = 3'd3,
    ST_ERROR     = 3'd4,
    ST_FATAL     = 3'd5
  } state_e;

  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_SEC = (SWITCH_SEC > HOPPER_SEC) ? SWITCH_SEC : HOPPER_SEC;
  localparam int TW      = (MAX_SEC > 1) ? $clog2(MAX_SEC) + 1 : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] HOP_LAST   = TW'(HOPPER_SEC - 1);
  localparam logic [TW-1:0] SW_LAST    = TW'(SWITCH_SEC - 1);

  state_e        state_q, state_d;
  logic [11:0]   pills_q, pills_d;
  logic [7:0]    bottles_q, bottles_d;
  logic [1:0]    err_q, err_d;
  logic          switch_req_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tick_q, tick_d;

  logic          load_s;
  logic          take_pill_s;
  logic          timing_s;
  logic          expired_s;
  logic          cfg_ok_s;
  logic [11:0]   pill_inc_s;
  logic [7:0]    bottle_inc_s;

  function automatic logic [11:0] bcd_inc3(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] == 4'd9) begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end else begin
        r[7:4] = v[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic cfg_valid(input logic [11:0] tp, input logic [7:0] tb);
    logic digits_ok;
    digits_ok = (tp[11:8] <= 4'd9) && (tp[7:4] <= 4'd9) && (tp[3:0] <= 4'd9) &&
                (tb[7:4] <= 4'd9) && (tb[3:0] <= 4'd9);
    return digits_ok && (tp != 12'd0) && (tb != 8'd0);
  endfunction

  assign pill_inc_s   = bcd_inc3(pills_q);
  assign bottle_inc_s = bcd_inc2(bottles_q);
  assign cfg_ok_s     = cfg_valid(target_pills, target_bottles);
  assign timing_s     = (state_q == ST_RUNNING) || (state_q == ST_SWITCHING);
  assign expired_s    = timing_s && (presc_q == PRESC_LAST) &&
                        (tick_q == ((state_q == ST_SWITCHING) ? SW_LAST : HOP_LAST));

  // Next-state, count and error-code logic; estop overrides every state.
  always_comb begin
    state_d     = state_q;
    pills_d     = pills_q;
    bottles_d   = bottles_q;
    err_d       = err_q;
    load_s      = 1'b0;
    take_pill_s = 1'b0;
    if (estop) begin
      state_d = ST_FATAL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && cfg_ok_s) begin
            state_d   = ST_RUNNING;
            pills_d   = 12'd0;
            bottles_d = 8'd0;
            err_d     = 2'd0;
            load_s    = 1'b1;
          end else if (start) begin
            err_d = 2'd3;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUNNING: begin
          if (pill_pulse) begin
            take_pill_s = 1'b1;
          end else if (expired_s) begin
            state_d = ST_ERROR;
            err_d   = 2'd1;
          end else begin
            state_d = ST_RUNNING;
          end
        end
        ST_SWITCHING: begin
          if (expired_s && conveyor_ok) begin
            state_d = ST_RUNNING;
            load_s  = 1'b1;
          end else if (expired_s) begin
            state_d = ST_ERROR;
            err_d   = 2'd2;
          end else begin
            state_d = ST_SWITCHING;
          end
        end
        ST_ERROR: begin
`ifdef FILL_SEQ_AUTO_RESUME_EN
          if ((err_q == 2'd1) && pill_pulse) begin
            err_d       = 2'd0;
            take_pill_s = 1'b1;
          end else if ((err_q == 2'd2) && conveyor_ok) begin
            err_d   = 2'd0;
            state_d = ST_RUNNING;
            load_s  = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
`else
          if (ack && ((err_q == 2'd1) || ((err_q == 2'd2) && conveyor_ok))) begin
            err_d   = 2'd0;
            state_d = ST_RUNNING;
            load_s  = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
`endif
        end
        ST_DONE: begin
          if (ack) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_FATAL: begin
          if (ack) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FATAL;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // A counted pill either completes the bottle or restarts the hopper supervision.
    if (take_pill_s) begin
      load_s = 1'b1;
      if (pill_inc_s == target_pills) begin
        bottles_d = bottle_inc_s;
        if (bottle_inc_s == target_bottles) begin
          state_d = ST_DONE;
          pills_d = pill_inc_s;
        end else begin
          state_d = ST_SWITCHING;
          pills_d = 12'd0;
        end
      end else begin
        state_d = ST_RUNNING;
        pills_d = pill_inc_s;
      end
    end else begin
      load_s = load_s;
    end
  end

  // Shared prescaler and tick counter; only one supervision timer is ever active.
  always_comb begin
    presc_d = presc_q;
    tick_d  = tick_q;
    if (load_s) begin
      presc_d = '0;
      tick_d  = '0;
    end else if (timing_s && (presc_q == PRESC_LAST)) begin
      presc_d = '0;
      tick_d  = tick_q + TW'(1);
    end else if (timing_s) begin
      presc_d = presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // Registered state, counts, timers and outputs with synchronous clear.
  always_ff @(posedge clk_1khz) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      pills_q      <= 12'd0;
      bottles_q    <= 8'd0;
      err_q        <= 2'd0;
      switch_req_q <= 1'b0;
      presc_q      <= '0;
      tick_q       <= '0;
    end else begin
      state_q      <= state_d;
      pills_q      <= pills_d;
      bottles_q    <= bottles_d;
      err_q        <= err_d;
      switch_req_q <= (state_d == ST_SWITCHING);
      presc_q      <= presc_d;
      tick_q       <= tick_d;
    end
  end

  assign state       = state_q;
  assign now_pills   = pills_q;
  assign now_bottles = bottles_q;
  assign switch_req  = switch_req_q;
  assign err_code    = err_q;

endmodule

// File: tb/tb_fill_sequencer.sv
// Self-checking bench for fill_sequencer: directed scenarios plus randomized traffic,
// every output compared each cycle against a cycle-countdown reference model.
module tb_fill_sequencer;

  localparam int TD  = 4;
  localparam int SWS = 2;
  localparam int HPS = 5;

  logic        clk_1khz = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic        estop = 1'b0;
  logic [11:0] target_pills = 12'h003;
  logic [7:0]  target_bottles = 8'h02;
  logic        pill_pulse = 1'b0;
  logic        conveyor_ok = 1'b1;
  logic [2:0]  state;
  logic [11:0] now_pills;
  logic [7:0]  now_bottles;
  logic        switch_req;
  logic [1:0]  err_code;

  fill_sequencer #(.TICK_DIV(TD), .SWITCH_SEC(SWS), .HOPPER_SEC(HPS)) dut (
    .clk_1khz(clk_1khz), .clr(clr), .start(start), .ack(ack), .estop(estop),
    .target_pills(target_pills), .target_bottles(target_bottles),
    .pill_pulse(pill_pulse), .conveyor_ok(conveyor_ok),
    .state(state), .now_pills(now_pills), .now_bottles(now_bottles),
    .switch_req(switch_req), .err_code(err_code)
  );

  always #5 clk_1khz = ~clk_1khz;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state as status digit, counts as plain integers, timer as cycles left.
  int m_state = 0, m_pills = 0, m_bottles = 0, m_err = 0, m_left = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int bcd_val(input logic [11:0] v);
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic bit cfg_valid(input logic [11:0] tp, input logic [7:0] tb);
    logic [19:0] all;
    all = {tp, tb};
    for (int i = 0; i < 5; i++) if (all[i*4 +: 4] > 4'd9) return 1'b0;
    return (bcd_val(tp) != 0) && (bcd_val({4'h0, tb}) != 0);
  endfunction

  task automatic model_take_pill();
    int p;
    p = m_pills + 1;
    if (p == bcd_val(target_pills)) begin
      m_bottles++;
      if (m_bottles == bcd_val({4'h0, target_bottles})) begin
        m_state = 3; m_pills = p;
      end else begin
        m_state = 2; m_pills = 0; m_left = SWS * TD;
      end
    end else begin
      m_state = 1; m_pills = p; m_left = HPS * TD;
    end
  endtask

  task automatic model_step();
    bit expired;
    expired = 1'b0;
    if (m_state == 1 || m_state == 2) begin
      m_left--;
      expired = (m_left == 0);
    end
    if (clr) begin
      m_state = 0; m_pills = 0; m_bottles = 0; m_err = 0;
    end else if (estop) begin
      m_state = 5;
    end else begin
      case (m_state)
        0: if (start) begin
             if (cfg_valid(target_pills, target_bottles)) begin
               m_state = 1; m_pills = 0; m_bottles = 0; m_err = 0; m_left = HPS * TD;
             end else m_err = 3;
           end
        1: if (pill_pulse) model_take_pill();
           else if (expired) begin m_state = 4; m_err = 1; end
        2: if (expired) begin
             if (conveyor_ok) begin m_state = 1; m_left = HPS * TD; end
             else begin m_state = 4; m_err = 2; end
           end
        4: begin
`ifdef FILL_SEQ_AUTO_RESUME_EN
             if (m_err == 1 && pill_pulse) begin m_err = 0; model_take_pill(); end
             else if (m_err == 2 && conveyor_ok) begin m_err = 0; m_state = 1; m_left = HPS * TD; end
`else
             if (ack && (m_err == 1 || conveyor_ok)) begin m_err = 0; m_state = 1; m_left = HPS * TD; end
`endif
           end
        3, 5: if (ack) m_state = 0;
        default: m_state = 0;
      endcase
    end
  endtask

  // One clock: model advances on the edge, all outputs compared 1 time unit later.
  task automatic step_cycle();
    @(posedge clk_1khz);
    model_step();
    #1;
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("now_pills", 32'(now_pills), 32'(to_bcd(m_pills)));
    check_eq("now_bottles", 32'(now_bottles), 32'(to_bcd(m_bottles)));
    check_eq("switch_req", 32'(switch_req), 32'(m_state == 2));
    check_eq("err_code", 32'(err_code), 32'(m_err));
  endtask

  task automatic pulse_start();
    start = 1'b1; step_cycle(); start = 1'b0;
  endtask

  task automatic pulse_pill();
    pill_pulse = 1'b1; step_cycle(); pill_pulse = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step_cycle(); ack = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1; step_cycle(); clr = 1'b0;
  endtask

  int sw_cycles, done, n, saw_010, saw_100;
  logic [11:0] prev;
  int pill_div;

  initial begin
    // Reset
    step_cycle();
    step_cycle();
    clr = 1'b0;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_pills", 32'(now_pills), 32'd0);

    // Full batch 003/02, pill every third cycle
    target_pills = 12'h003; target_bottles = 8'h02; conveyor_ok = 1'b1;
    pulse_start();
    check_eq("batch_run", 32'(state), 32'd1);
    sw_cycles = 0; done = 0;
    for (int i = 0; i < 200 && done == 0; i++) begin
      pill_pulse = (i % 3 == 2);
      step_cycle();
      pill_pulse = 1'b0;
      if (state == 3'd2) sw_cycles++;
      if (state == 3'd3) done = 1;
    end
    check_eq("batch_done", 32'(done), 32'd1);
    check_eq("switch_len", 32'(sw_cycles), 32'd8);
    check_eq("batch_bottles", 32'(now_bottles), 32'h02);
    check_eq("batch_pills", 32'(now_pills), 32'h003);
    pulse_ack();
    check_eq("batch_ack_idle", 32'(state), 32'd0);

    // BCD carry, target 120/01
    target_pills = 12'h120; target_bottles = 8'h01;
    pulse_start();
    done = 0; saw_010 = 0; saw_100 = 0;
    for (int i = 0; i < 300 && done == 0; i++) begin
      prev = now_pills;
      pill_pulse = (i % 2 == 0);
      step_cycle();
      pill_pulse = 1'b0;
      if (prev == 12'h009 && now_pills == 12'h010) saw_010 = 1;
      if (prev == 12'h099 && now_pills == 12'h100) saw_100 = 1;
      if (state == 3'd3) done = 1;
    end
    check_eq("carry_010", 32'(saw_010), 32'd1);
    check_eq("carry_100", 32'(saw_100), 32'd1);
    check_eq("carry_done", 32'(done), 32'd1);
    check_eq("carry_final", 32'(now_pills), 32'h120);
    pulse_ack();

    // Hopper starvation
    target_pills = 12'h005; target_bottles = 8'h02;
    pulse_start();
    step_cycle();
    pulse_pill();
    step_cycle();
    pulse_pill();
    n = 0;
    for (int i = 0; i < 40 && state != 3'd4; i++) begin
      step_cycle();
      n++;
    end
    check_eq("hopper_delay", 32'(n), 32'd20);
    check_eq("hopper_err", 32'(err_code), 32'd1);
    pulse_pill();
`ifdef FILL_SEQ_AUTO_RESUME_EN
    check_eq("hopper_resume", 32'(state), 32'd1);
    check_eq("hopper_counted", 32'(now_pills), 32'h003);
`else
    check_eq("hopper_drop", 32'(state), 32'd4);
    check_eq("hopper_dropped", 32'(now_pills), 32'h002);
    pulse_ack();
    check_eq("hopper_ack", 32'(state), 32'd1);
`endif
    check_eq("hopper_clear", 32'(err_code), 32'd0);
    do_clear();

    // Conveyor stall at switch expiry
    target_pills = 12'h002; target_bottles = 8'h03;
    pulse_start();
    pulse_pill();
    pulse_pill();
    check_eq("stall_switch", 32'(state), 32'd2);
    conveyor_ok = 1'b0;
    for (int i = 0; i < 20 && state == 3'd2; i++) step_cycle();
    check_eq("stall_state", 32'(state), 32'd4);
    check_eq("stall_err", 32'(err_code), 32'd2);
    conveyor_ok = 1'b1;
    step_cycle();
`ifdef FILL_SEQ_AUTO_RESUME_EN
    check_eq("stall_resume", 32'(state), 32'd1);
`else
    check_eq("stall_hold", 32'(state), 32'd4);
    pulse_ack();
    check_eq("stall_ack", 32'(state), 32'd1);
`endif
    do_clear();

    // Emergency stop mid-SWITCHING
    pulse_start();
    pulse_pill();
    pulse_pill();
    step_cycle();
    step_cycle();
    estop = 1'b1;
    step_cycle();
    check_eq("estop_fatal", 32'(state), 32'd5);
    check_eq("estop_bottles", 32'(now_bottles), 32'h01);
    pulse_ack();
    check_eq("estop_ack_ignored", 32'(state), 32'd5);
    estop = 1'b0;
    step_cycle();
    pulse_ack();
    check_eq("estop_ack_idle", 32'(state), 32'd0);
    check_eq("estop_held", 32'(now_bottles), 32'h01);

    // Bad config, then clr mid-RUNNING
    target_pills = 12'h000; target_bottles = 8'h02;
    pulse_start();
    check_eq("bad_zero", 32'(err_code), 32'd3);
    target_pills = 12'h0A0;
    pulse_start();
    check_eq("bad_digit", 32'(err_code), 32'd3);
    check_eq("bad_idle", 32'(state), 32'd0);
    target_pills = 12'h005;
    pulse_start();
    check_eq("good_start", 32'(err_code), 32'd0);
    pulse_pill();
    pulse_pill();
    do_clear();
    check_eq("clr_state", 32'(state), 32'd0);
    check_eq("clr_pills", 32'(now_pills), 32'd0);

    // Randomized traffic
    pill_div = 3;
    for (int c = 0; c < 4000; c++) begin
      start = 1'b0; ack = 1'b0; pill_pulse = 1'b0; clr = 1'b0;
      if (c % 300 == 0) pill_div = (c % 900 == 0) ? 2 : ((c % 600 == 0) ? 15 : 6);
      if (m_state == 0 && $urandom_range(0, 9) == 0) begin
        target_pills   = to_bcd(int'($urandom_range(1, 12)));
        target_bottles = 8'(to_bcd(int'($urandom_range(1, 3))));
        if ($urandom_range(0, 7) == 0) target_pills = 12'h000;
        else if ($urandom_range(0, 7) == 0) target_pills = 12'h0B2;
        start = 1'b1;
      end else begin
        start = ($urandom_range(0, 49) == 0);
      end
      pill_pulse = ($urandom_range(0, pill_div - 1) == 0);
      if ($urandom_range(0, 29) == 0) conveyor_ok = ~conveyor_ok;
      estop = ($urandom_range(0, 199) == 0);
      ack   = ($urandom_range(0, 9) == 0);
      clr   = ($urandom_range(0, 799) == 0);
      step_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fill_sequencer.md
# fill_sequencer

Sequencing controller for the pill-bottling datapath. Counts hopper pill pulses into the current bottle in BCD, requests bottle changes from the conveyor, and supervises hopper-starvation and conveyor-stall timeouts. Sits between the button/settings front end, which supplies the BCD targets and start/ack pulses, and the display/beeper back end, which consumes `state`, the BCD counts and `err_code`. State encoding matches the existing status-digit encoding (0–5).

## Interface
- `TICK_DIV`, 1000: clk cycles per 1 s timer tick.
- `SWITCH_SEC`, 2: bottle-change dwell, in ticks.
- `HOPPER_SEC`, 5: maximum allowed gap between pills, in ticks.

Ports:
- `clk_1khz` in 1: sole clock, rising edge.
- `clr` in 1: reset. Synchronous, active-high.
- `start` in 1: single-cycle pulse; begins a batch.
- `ack` in 1: single-cycle pulse; acknowledges DONE/FATAL (and ERROR when auto-resume is compiled out).
- `estop` in 1: emergency-stop level.
- `target_pills` in 12: BCD digits {hundreds, tens, ones}.
- `target_bottles` in 8: BCD digits {tens, ones}.
- `pill_pulse` in 1: single-cycle pulse, one per pill from the hopper edge detector.
- `conveyor_ok` in 1: conveyor-running level.
- `state` out 3: 0 IDLE, 1 RUNNING, 2 SWITCHING, 3 DONE, 4 ERROR, 5 FATAL.
- `now_pills` out 12: BCD pills in the current bottle.
- `now_bottles` out 8: BCD completed bottles.
- `switch_req` out 1: high throughout SWITCHING.
- `err_code` out 2: 0 none, 1 hopper empty, 2 conveyor stall, 3 bad config.

## Operation
- All outputs are registered. On `clr`, all outputs are 0 (IDLE), and the timers and prescaler are cleared.
- Priority: `clr` > `estop` > everything else. When `estop` is 1 in any state, the next state is FATAL; the counts are held.
- **IDLE:**
  - `start` with a valid config goes to RUNNING. This clears `now_pills`/`now_bottles`, sets `err_code` to 0 and loads the hopper timer.
  - A config is valid when every digit is ≤9, `target_pills` ≠ 000 and `target_bottles` ≠ 00.
  - An invalid config leaves the block in IDLE and sets `err_code` to 3. The code stays at 3 until the next valid start.
  - `start` is ignored in every state other than IDLE.
- **RUNNING:**
  - `pill_pulse` increments `now_pills` as a BCD counter (ones carry into tens, tens into hundreds) and reloads the hopper timer.
  - When the incremented value equals `target_pills`, `now_bottles` increments in BCD.
    - If the new bottle count equals `target_bottles`, go to DONE.
    - Otherwise go to SWITCHING, clear `now_pills` and load the switch timer.
  - If the hopper timer expires, go to ERROR with `err_code` = 1.
  - If `pill_pulse` and hopper expiry occur in the same cycle, the pill wins and the timer is reloaded.
- **SWITCHING:**
  - `pill_pulse` is ignored.
  - When the switch timer expires and `conveyor_ok` = 1, go to RUNNING and reload the hopper timer.
  - When the switch timer expires and `conveyor_ok` = 0, go to ERROR with `err_code` = 2.
- **ERROR:** `now_pills`/`now_bottles` are preserved. The resume rules are given under Configuration. On resume, `err_code` returns to 0.
- **DONE:** `ack` goes to IDLE. The counts are held for display.
- **FATAL:** `ack` while `estop` = 0 goes to IDLE. The counts are held. `ack` while `estop` = 1 is ignored.
- `now_pills` never exceeds `target_pills`, and the BCD counters never wrap within a valid batch.

## Timing
- An input sampled at edge N is visible on the outputs after edge N; the latency is one cycle for every transition.
- Each timer is a tick counter driven by a prescaler. The prescaler is reset whenever its timer is loaded.
- A timer loaded at edge N expires at edge N + SEC×`TICK_DIV`, and the state changes on that same edge.
- The hopper timer runs only in RUNNING. The switch timer runs only in SWITCHING.
- A `clr` asserted mid-batch gives IDLE with all outputs at 0 on the following edge.

## Configuration
- `FILL_SEQ_AUTO_RESUME_EN` defined:
  - From ERROR with code 1, resume to RUNNING on `pill_pulse`. That pill is counted and completion is checked as in RUNNING.
  - From ERROR with code 2, resume to RUNNING when `conveyor_ok` = 1, and load the hopper timer.
- Macro undefined:
  - ERROR is held until `ack` arrives and the fault condition is clear.
  - For code 1, `ack` alone resumes, the hopper timer is reloaded and the pill is not counted.
  - For code 2, resume requires `ack` with `conveyor_ok` = 1.
  - A `pill_pulse` that arrives while in ERROR is dropped.

## Test plan
- **Full batch** (`TICK_DIV`=4, targets 003/02, `conveyor_ok`=1, pills every 3 cycles) -> the sequence is RUNNING, then SWITCHING for exactly 8 cycles, then RUNNING, then DONE, with `now_bottles` = 02 and `now_pills` = 003. `ack` then gives IDLE.
- **BCD carry** (target 120/01) -> `now_pills` steps 009→010 and 099→100, and DONE occurs at 120.
- **Hopper starvation** (pills stop during RUNNING) -> ERROR with code 1 exactly 20 cycles after the last pill. The next pill resumes RUNNING (macro on) or is dropped (macro off).
- **Conveyor stall** (`conveyor_ok`=0 at switch expiry) -> ERROR with code 2. Raising `conveyor_ok` resumes RUNNING (macro on) or requires `ack` as well (macro off).
- **Emergency stop** (`estop` pulsed mid-SWITCHING) -> FATAL next cycle, counts held. `ack` while `estop` = 1 is ignored; `ack` after `estop` falls gives IDLE.
- **Bad config, then clr** (`start` with target_pills = 000, then target_pills = 0A0) -> stays IDLE with `err_code` = 3. A valid start clears the code. `clr` mid-RUNNING zeroes all outputs.
